// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Double-dabble correction for one digit: a digit of 5 or more would
    // carry past 9 when doubled, so pre-bias it by 3.
    function automatic logic [BCD_W-1:0] dabble_digit(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Combinational add-3 correction applied to every digit of the BCD register.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [DIGITS*BCD_W-1:0] bcd_i,
    output logic [DIGITS*BCD_W-1:0] bcd_o
);

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
        bcd_o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_o[i*BCD_W +: BCD_W] = dabble_digit(bcd_i[i*BCD_W +: BCD_W]);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle, ready/valid on both sides.
// Define BCD_SIGNED_EN to treat in_bin as two's complement (magnitude + out_sign).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGITS*BCD_W-1:0] out_bcd,
    output logic                    out_ovf,
    output logic                    out_sign
);

    localparam int CNT_W    = $clog2(BIN_W + 1);
    localparam int BCD_BITS = DIGITS * BCD_W;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIN_W-1:0]    bin_q;
    logic [BCD_BITS-1:0] bcd_q;
    logic                ovf_q;
    logic                out_valid_q;
    logic [BCD_BITS-1:0] out_bcd_q;
    logic                out_ovf_q;

    logic [BIN_W-1:0]    operand_d;
    logic [BCD_BITS-1:0] bcd_corr;
    logic [BCD_BITS-1:0] bcd_d;
    logic [BIN_W-1:0]    bin_d;
    logic                ovf_d;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_dabble (
        .bcd_i(bcd_q),
        .bcd_o(bcd_corr)
    );

    // Shift {corrected digits, operand} left by one; the bit leaving the top digit is overflow.
    assign bcd_d = {bcd_corr[BCD_BITS-2:0], bin_q[BIN_W-1]};
    assign bin_d = {bin_q[BIN_W-2:0], 1'b0};
    assign ovf_d = ovf_q | bcd_corr[BCD_BITS-1];

`ifdef BCD_SIGNED_EN
    logic sign_q;
    logic out_sign_q;

    // Negating the most negative value wraps to itself, which read unsigned is 2^(BIN_W-1).
    assign operand_d = in_bin[BIN_W-1] ? (~in_bin + BIN_W'(1)) : in_bin;
    assign out_sign  = out_sign_q;
`else
    assign operand_d = in_bin;
    assign out_sign  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_q      <= 1'b0;
            out_sign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= operand_d;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= CNT_W'(BIN_W);
                        state_q <= SHIFT;
`ifdef BCD_SIGNED_EN
                        sign_q  <= in_bin[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_bcd_q   <= bcd_d;
                        out_ovf_q   <= ovf_d;
`ifdef BCD_SIGNED_EN
                        out_sign_q  <= sign_q;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: directed literal cases plus randomized traffic against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_ovf;
    logic        out_sign;

    logic        in_valid4;
    logic        in_ready4;
    logic [15:0] in_bin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [15:0] out_bcd4;
    logic        out_ovf4;
    logic        out_sign4;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf), .out_sign(out_sign)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_bin(in_bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_bcd(out_bcd4), .out_ovf(out_ovf4), .out_sign(out_sign4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event within bound, expected one at %0t", name, $time);
    endtask

    // Reference: decimal digits by repeated division; anything left over is overflow.
    function automatic void to_bcd(input longint v, input int digits,
                                   output logic [19:0] bcd, output logic ovf);
        bcd = '0;
        for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        ovf = (v != 0);
    endfunction

    // Transaction-level model: idle accepts, result appears 16 edges later, held until out_ready.
    logic        m_ready, m_valid, m_ovf, m_sign;
    logic [19:0] m_bcd;
    logic        p_ovf, p_sign;
    logic [19:0] p_bcd;
    int          m_wait;

    always @(posedge clk) begin
        logic [19:0] b;
        logic        o;
        longint      mag;
        logic        s;
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_ovf   <= 1'b0;
            m_sign  <= 1'b0;
            m_wait  <= 0;
        end else if (m_ready) begin
            if (in_valid) begin
`ifdef BCD_SIGNED_EN
                s   = in_bin[15];
                mag = s ? (65536 - longint'(in_bin)) : longint'(in_bin);
`else
                s   = 1'b0;
                mag = longint'(in_bin);
`endif
                to_bcd(mag, 5, b, o);
                p_bcd   <= b;
                p_ovf   <= o;
                p_sign  <= s;
                m_ready <= 1'b0;
                m_wait  <= 16;
            end
        end else if (!m_valid) begin
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_bcd   <= p_bcd;
                m_ovf   <= p_ovf;
                m_sign  <= p_sign;
            end
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_in_ready", in_ready, m_ready);
            check("model_out_valid", out_valid, m_valid);
            check("model_out_bcd", out_bcd, m_bcd);
            check("model_out_ovf", out_ovf, m_ovf);
            check("model_out_sign", out_sign, m_sign);
        end
    end

    task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd,
                           input logic exp_ovf, input logic exp_sign, input int hold);
        int n;
        bit ok;
        ok = 0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("idle_wait");
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin   = 16'($urandom);
        ok = 0;
        n  = 0;
        while (n < 100) begin
            n++;
            @(posedge clk);
            #1;
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("result_wait");
        check("latency", 64'(n), 64'd16);
        check("out_bcd", out_bcd, exp_bcd);
        check("out_ovf", out_ovf, exp_ovf);
        check("out_sign", out_sign, exp_sign);
        if (hold > 0) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_bin = 16'($urandom);
            check("hold_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_bcd", out_bcd, exp_bcd);
            check("hold_ovf", out_ovf, exp_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("ready_after_release", in_ready, 1'b1);
        check("valid_after_release", out_valid, 1'b0);
    endtask

    task automatic convert4(input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        bit ok;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready4) begin ok = 1; break; end
        end
        if (!ok) timeout("idle_wait4");
        in_bin4   = v;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid4) begin ok = 1; break; end
        end
        if (!ok) timeout("result_wait4");
        check("d4_out_bcd", out_bcd4, exp_bcd);
        check("d4_out_ovf", out_ovf4, exp_ovf);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_bin     = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_bin4    = '0;
        out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_bcd", out_bcd, 20'h0);
        check("reset_out_ovf", out_ovf, 1'b0);
        check("reset_out_sign", out_sign, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

`ifdef BCD_SIGNED_EN
        convert(16'hFFFF, 20'h00001, 1'b0, 1'b1, 0);
        convert(16'h8000, 20'h32768, 1'b0, 1'b1, 0);
`else
        convert(16'hFFFF, 20'h65535, 1'b0, 1'b0, 0);
        convert(16'h8000, 20'h32768, 1'b0, 1'b0, 0);
`endif
        convert(16'd0,  20'h00000, 1'b0, 1'b0, 0);
        convert(16'd9,  20'h00009, 1'b0, 1'b0, 0);
        convert(16'd10, 20'h00010, 1'b0, 1'b0, 5);

        // Abort mid-conversion: reset on the 7th shift edge.
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        in_bin   = 16'd4321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_bcd", out_bcd, 20'h0);
        check("abort_out_ovf", out_ovf, 1'b0);
        check("abort_out_sign", out_sign, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        convert(16'd1234, 20'h01234, 1'b0, 1'b0, 0);

        convert4(16'd10000, 16'h0000, 1'b1);
        convert4(16'd9999,  16'h9999, 1'b0);

        // Random traffic: random valids, values biased to edge cases, back-pressure and rare resets.
        repeat (3000) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 5))
                0:       in_bin = 16'd0;
                1:       in_bin = 16'hFFFF;
                2:       in_bin = 16'h8000;
                3:       in_bin = 16'($urandom_range(0, 99));
                default: in_bin = 16'($urandom);
            endcase
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
